pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the pipeline core. Holds the fetch PC, presents it to instruction fetch through a valid/ready handshake, advances it by a fixed increment on each accepted fetch, and applies redirect and trap targets with fixed priority. It detects misaligned redirect targets, halts on them, and supports external halt/resume. It keeps a count of accepted fetches.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_incr.sv | 14 +
 rtl/pc_gen.sv | 128 ++++++++++++
 tb/tb_pc_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  // Low-bit mask that must be zero in an aligned target.
  function automatic logic [63:0] align_mask(input int unsigned align);
    return 64'(align) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-path adder: pc + INC, wrapping modulo 2^XLEN.
module pc_incr
  import pc_gen_pkg::*;
#(
  parameter int          XLEN = DEF_XLEN,
  parameter int unsigned INC  = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_inc_o
);

  assign pc_inc_o = pc_i + XLEN'(INC);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: valid/ready handshake, trap > redirect > sequential
// priority, misaligned-redirect detection, halt/resume and a fetch counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN        = 4,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             misalign_o,
  output logic [XLEN-1:0]  badaddr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(ALIGN));

  state_e           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_misalign;
  logic [XLEN-1:0]  r_badaddr;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_misalign_nxt;
  logic [XLEN-1:0]  w_badaddr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [XLEN-1:0]  w_pc_inc;
  logic [XLEN-1:0]  w_trap_tgt;
  logic             w_redir_bad;
  logic             w_hs;

  pc_incr #(.XLEN(XLEN), .INC(INC)) u_pc_incr (
    .pc_i     (r_pc),
    .pc_inc_o (w_pc_inc)
  );

  assign w_trap_tgt  = trap_pc_i & ~ALIGN_MASK;
  assign w_redir_bad = (redirect_pc_i & ALIGN_MASK) != {XLEN{1'b0}};
  assign pc_valid_o  = (r_state == ST_RUN);
  assign w_hs        = pc_valid_o & pc_ready_i;

  // Next-state, next-PC, sticky-error and counter decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = r_misalign;
    w_badaddr_nxt  = r_badaddr;
    w_cnt_nxt      = w_hs ? (r_cnt + CNT_W'(1)) : r_cnt;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_state_nxt = halt_i ? ST_HALT : ST_RUN;
        if (trap_i) begin
          w_pc_nxt       = w_trap_tgt;
          w_misalign_nxt = 1'b0;
          w_badaddr_nxt  = {XLEN{1'b0}};
        end else if (redirect_i && w_redir_bad) begin
          w_misalign_nxt = 1'b1;
          w_badaddr_nxt  = redirect_pc_i;
          w_state_nxt    = ST_HALT;
        end else if (redirect_i) begin
          w_pc_nxt = redirect_pc_i;
        end else if (w_hs) begin
          w_pc_nxt = w_pc_inc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_HALT: begin
        // Trap entry beats resume; redirect and halt are ignored here.
        if (trap_i) begin
          w_pc_nxt       = w_trap_tgt;
          w_misalign_nxt = 1'b0;
          w_badaddr_nxt  = {XLEN{1'b0}};
          w_state_nxt    = ST_RUN;
        end else if (resume_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // State, PC, error capture and fetch counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
      r_badaddr  <= {XLEN{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
      r_badaddr  <= w_badaddr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign pc_o        = r_pc;
  assign misalign_o  = r_misalign;
  assign badaddr_o   = r_badaddr;
  assign state_o     = r_state;
  assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table through a scoreboard queue,
// plus reset, async-reset and wrap-around sequences.
module tb_pc_gen;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] tpc;
    logic        halt;
    logic        resume;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [1:0]  e_state;
    logic        e_mis;
    logic [31:0] e_bad;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_pc_i = 32'h0;
  logic        halt_i = 1'b0;
  logic        resume_i = 1'b0;

  logic [31:0] d0_pc, d0_bad, d0_cnt;
  logic        d0_valid, d0_mis;
  logic [1:0]  d0_state;
  logic [31:0] d1_pc, d1_bad;
  logic        d1_valid, d1_mis;
  logic [1:0]  d1_state, d1_cnt;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pc_gen u_dut0 (
    .clk(clk), .rst(rst), .pc_o(d0_pc), .pc_valid_o(d0_valid),
    .pc_ready_i(pc_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .trap_i(trap_i), .trap_pc_i(trap_pc_i), .halt_i(halt_i), .resume_i(resume_i),
    .misalign_o(d0_mis), .badaddr_o(d0_bad), .state_o(d0_state), .fetch_cnt_o(d0_cnt)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .INC(4), .ALIGN(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .pc_o(d1_pc), .pc_valid_o(d1_valid),
    .pc_ready_i(pc_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .trap_i(trap_i), .trap_pc_i(trap_pc_i), .halt_i(halt_i), .resume_i(resume_i),
    .misalign_o(d1_mis), .badaddr_o(d1_bad), .state_o(d1_state), .fetch_cnt_o(d1_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic trap, input logic [31:0] tpc, input logic halt,
                              input logic resume, input logic [31:0] e_pc, input logic e_valid,
                              input logic [1:0] e_state, input logic e_mis,
                              input logic [31:0] e_bad, input logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.trap = trap; v.tpc = tpc;
    v.halt = halt; v.resume = resume; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_state = e_state; v.e_mis = e_mis; v.e_bad = e_bad; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check_d0(input string tag, input logic [31:0] pc, input logic valid,
                          input logic [1:0] st, input logic mis, input logic [31:0] bad,
                          input logic [31:0] cnt);
    n_vec++;
    chk({tag, ".pc"}, 64'(d0_pc), 64'(pc));
    chk({tag, ".valid"}, 64'(d0_valid), 64'(valid));
    chk({tag, ".state"}, 64'(d0_state), 64'(st));
    chk({tag, ".misalign"}, 64'(d0_mis), 64'(mis));
    chk({tag, ".badaddr"}, 64'(d0_bad), 64'(bad));
    chk({tag, ".fetch_cnt"}, 64'(d0_cnt), 64'(cnt));
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    pc_ready_i = v.rdy; redirect_i = v.redir; redirect_pc_i = v.rpc;
    trap_i = v.trap; trap_pc_i = v.tpc; halt_i = v.halt; resume_i = v.resume;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: queue empty at vector %0d", idx);
    end else begin
      e = exp_q.pop_front();
      check_d0($sformatf("vec%0d", idx), e.e_pc, e.e_valid, e.e_state, e.e_mis, e.e_bad, e.e_cnt);
    end
  endtask

  initial begin
    // rdy redir rpc trap tpc halt resume | pc valid state mis bad cnt
    vecs.push_back(mk(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    1'b1, 2'd1, 1'b0, 32'h0,   32'd0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h4,    1'b1, 2'd1, 1'b0, 32'h0,   32'd1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h8,    1'b1, 2'd1, 1'b0, 32'h0,   32'd2));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'hC,    1'b1, 2'd1, 1'b0, 32'h0,   32'd3));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h10,   1'b1, 2'd1, 1'b0, 32'h0,   32'd4));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h10,   1'b1, 2'd1, 1'b0, 32'h0,   32'd4));
    vecs.push_back(mk(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h200,  1'b1, 2'd1, 1'b0, 32'h0,   32'd4));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h204,  1'b1, 2'd1, 1'b0, 32'h0,   32'd5));
    vecs.push_back(mk(1'b1, 1'b1, 32'h300, 1'b1, 32'h1003, 1'b0, 1'b0, 32'h1000, 1'b1, 2'd1, 1'b0, 32'h0, 32'd6));
    vecs.push_back(mk(1'b0, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000, 1'b0, 2'd2, 1'b1, 32'h202, 32'd6));
    vecs.push_back(mk(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 1'b0, 2'd2, 1'b1, 32'h202, 32'd6));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b1, 2'd1, 1'b0, 32'h0,   32'd6));
    vecs.push_back(mk(1'b0, 1'b1, 32'h40,  1'b0, 32'h0, 1'b0, 1'b0, 32'h40,   1'b1, 2'd1, 1'b0, 32'h0,   32'd6));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h40,   1'b0, 2'd2, 1'b0, 32'h0,   32'd6));
    vecs.push_back(mk(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40,   1'b0, 2'd2, 1'b0, 32'h0,   32'd6));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h40,   1'b1, 2'd1, 1'b0, 32'h0,   32'd6));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h44,   1'b1, 2'd1, 1'b0, 32'h0,   32'd7));
    vecs.push_back(mk(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0, 32'h700,  1'b0, 2'd2, 1'b0, 32'h0,   32'd7));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h91, 1'b0, 1'b1, 32'h90,  1'b1, 2'd1, 1'b0, 32'h0,   32'd7));
    vecs.push_back(mk(1'b1, 1'b1, 32'h123, 1'b0, 32'h0, 1'b0, 1'b0, 32'h90,   1'b0, 2'd2, 1'b1, 32'h123, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h90,   1'b1, 2'd1, 1'b1, 32'h123, 32'd8));
    vecs.push_back(mk(1'b0, 1'b1, 32'h3FE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h90,   1'b0, 2'd2, 1'b1, 32'h3FE, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h90,   1'b1, 2'd1, 1'b1, 32'h3FE, 32'd8));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h2000, 1'b0, 1'b0, 32'h2000, 1'b1, 2'd1, 1'b0, 32'h0, 32'd9));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h2004, 1'b1, 2'd1, 1'b0, 32'h0,   32'd10));

    // Reset values appear without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_d0("reset", 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0);
    n_vec++;
    chk("reset.d1_pc", 64'(d1_pc), 64'(32'hFFFF_FFFC));
    chk("reset.d1_cnt", 64'(d1_cnt), 64'(2'd0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    pc_ready_i = 1'b1;
    #1;
    check_d0("boot", 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset mid-cycle, then boot and wrap on both instances.
    pc_ready_i = 1'b1; redirect_i = 1'b0; trap_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_d0("async_rst", 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e_pc1;
      logic [1:0]  e_cnt1;
      @(posedge clk);
      #1;
      e_pc1  = 32'hFFFF_FFFC + 32'(4 * i);
      e_cnt1 = 2'(i);
      check_d0($sformatf("seq%0d", i), 32'(4 * i), 1'b1, 2'd1, 1'b0, 32'h0, 32'(i));
      n_vec++;
      chk($sformatf("wrap%0d.pc", i), 64'(d1_pc), 64'(e_pc1));
      chk($sformatf("wrap%0d.cnt", i), 64'(d1_cnt), 64'(e_cnt1));
      chk($sformatf("wrap%0d.valid", i), 64'(d1_valid), 64'(1'b1));
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
